core_mem_arbiter: RTL

Shares one OBI manager port, such as a single-port SRAM bank or one crossbar slot, between the core's instruction and data OBI ports.
- Arbitrates requests round-robin and holds the selection stable until the downstream grants.
- Records the source of each accepted request in order, so responses are routed back to the correct requester.
- Sits between the core wrapper and the interconnect. Uses one clock and one synchronous active-high reset.

---
 rtl/core_mem_arbiter_pkg.sv | 23 ++
 rtl/core_mem_arb_rsp_fifo.sv | 63 ++++++
 rtl/core_mem_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/core_mem_arbiter_pkg.sv
// Shared types for the core instruction/data OBI arbiter: source IDs, FSM states,
// the default outstanding depth and the occupancy count type.
package core_mem_arbiter_pkg;

   localparam int unsigned ArbDefaultOutstanding = 2;

   typedef enum logic {
      ArbSrcInstr = 1'b0,
      ArbSrcData  = 1'b1
   } arb_src_e;

   typedef enum logic {
      ArbIdle    = 1'b0,
      ArbWaitGnt = 1'b1
   } arb_state_e;

   typedef logic [$clog2(ArbDefaultOutstanding):0] arb_cnt_t;

   function automatic arb_src_e arb_other(input arb_src_e src);
      return (src == ArbSrcData) ? ArbSrcInstr : ArbSrcData;
   endfunction

endpackage

// File: rtl/core_mem_arb_rsp_fifo.sv
// In-order FIFO of request sources; the head tells the arbiter which port owns
// the next response. Pushes while full and pops while empty are ignored.
module core_mem_arb_rsp_fifo
   import core_mem_arbiter_pkg::*;
#(
   parameter int unsigned Depth = ArbDefaultOutstanding
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic i_push,
   input  logic i_push_id,
   input  logic i_pop,
   output logic o_full,
   output logic o_empty,
   output logic o_head
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth) + 1;
   localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

   arb_src_e        r_mem [Depth];
   logic [PtrW-1:0] r_wptr;
   logic [PtrW-1:0] r_rptr;
   logic [CntW-1:0] r_count;
   logic            w_push;
   logic            w_pop;

   assign o_full  = (r_count == FullCnt);
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // NOTE: storage has no reset; an entry is only read once the count says it was written.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wptr] <= arb_src_e'(i_push_id);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= (r_wptr == LastIdx) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == LastIdx) ? '0 : r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one OBI manager port between the core's instruction
// and data ports. Define CORE_MEM_ARB_STATS_EN to build the instruction-stall counter.
module core_mem_arbiter
   import core_mem_arbiter_pkg::*;
#(
   parameter int unsigned MaxOutstanding = ArbDefaultOutstanding,
   parameter logic        DataPrioFirst  = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   input  logic [31:0] instr_addr_i,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mgr_req_o,
   input  logic        mgr_gnt_i,
   output logic        mgr_we_o,
   output logic [3:0]  mgr_be_o,
   output logic [31:0] mgr_addr_o,
   output logic [31:0] mgr_wdata_o,
   input  logic        mgr_rvalid_i,
   input  logic [31:0] mgr_rdata_i,
   input  logic        mgr_err_i,
   output logic        busy_o,
   output logic [15:0] stall_cnt_o
);

   arb_state_e r_state;
   arb_state_e w_state_next;
   arb_src_e   r_sel;
   arb_src_e   w_sel_next;
   arb_src_e   r_ptr;
   arb_src_e   w_ptr_next;
   arb_src_e   w_src;
   logic       w_req;
   logic       w_grant;
   logic       w_pop;
   logic       w_full;
   logic       w_empty;
   logic       w_head;

   core_mem_arb_rsp_fifo #(
      .Depth (MaxOutstanding)
   ) u_rsp_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .i_push    (w_grant),
      .i_push_id (w_src),
      .i_pop     (w_pop),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_head    (w_head)
   );

   // Full is judged on the registered count only; a same-cycle pop does not reopen it.
   always_comb begin
      w_state_next = r_state;
      w_sel_next   = r_sel;
      w_ptr_next   = r_ptr;
      w_src        = r_sel;
      w_req        = 1'b0;
      w_grant      = 1'b0;
      if (!rst_i) begin
         case (r_state)
            ArbIdle: begin
               if (!w_full && (instr_req_i || data_req_i)) begin
                  if (instr_req_i && data_req_i) begin
                     w_src = r_ptr;
                  end else if (data_req_i) begin
                     w_src = ArbSrcData;
                  end else begin
                     w_src = ArbSrcInstr;
                  end
                  w_req = 1'b1;
                  if (mgr_gnt_i) begin
                     w_grant    = 1'b1;
                     w_ptr_next = arb_other(w_src);
                  end else begin
                     w_sel_next   = w_src;
                     w_state_next = ArbWaitGnt;
                  end
               end
            end
            ArbWaitGnt: begin
               w_src = r_sel;
               w_req = 1'b1;
               if (mgr_gnt_i) begin
                  w_grant      = 1'b1;
                  w_ptr_next   = arb_other(r_sel);
                  w_state_next = ArbIdle;
               end
            end
            default: w_state_next = ArbIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ArbIdle;
         r_sel   <= ArbSrcInstr;
         r_ptr   <= arb_src_e'(DataPrioFirst);
      end else begin
         r_state <= w_state_next;
         r_sel   <= w_sel_next;
         r_ptr   <= w_ptr_next;
      end
   end

   // Payload reads zero whenever no request is presented downstream.
   always_comb begin
      mgr_we_o    = 1'b0;
      mgr_be_o    = 4'h0;
      mgr_addr_o  = 32'h0;
      mgr_wdata_o = 32'h0;
      if (w_req) begin
         if (w_src == ArbSrcData) begin
            mgr_we_o    = data_we_i;
            mgr_be_o    = data_be_i;
            mgr_addr_o  = data_addr_i;
            mgr_wdata_o = data_wdata_i;
         end else begin
            mgr_be_o    = 4'hF;
            mgr_addr_o  = instr_addr_i;
         end
      end
   end

   assign mgr_req_o   = w_req;
   assign instr_gnt_o = w_grant && (w_src == ArbSrcInstr);
   assign data_gnt_o  = w_grant && (w_src == ArbSrcData);

   assign w_pop          = mgr_rvalid_i && !rst_i;
   assign instr_rvalid_o = w_pop && !w_empty && (w_head == ArbSrcInstr);
   assign data_rvalid_o  = w_pop && !w_empty && (w_head == ArbSrcData);
   assign instr_rdata_o  = mgr_rdata_i;
   assign instr_err_o    = mgr_err_i;
   assign data_rdata_o   = mgr_rdata_i;
   assign data_err_o     = mgr_err_i;
   assign busy_o         = !w_empty && !rst_i;

`ifdef CORE_MEM_ARB_STATS_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stall_cnt <= 16'h0;
      end else if (instr_req_i && !instr_gnt_o && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`else
   assign stall_cnt_o = 16'h0;
`endif

endmodule
